// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one shared single-cycle-read memory.
// Each grant runs IDLE -> BUSY (WAIT_STATES+1 cycles) -> RESP (one-cycle ready pulse).
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        gnt_d;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        last_d;
  logic        grant_d_now;
  logic        final_busy;

  // Data wins unless fetch is also asking and data was granted last time.
  assign grant_d_now = d_req && (!if_req || !last_d);
  assign final_busy  = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (if_req || d_req) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt_d     <= 1'b0;
      acc_we    <= 1'b0;
      acc_addr  <= 32'd0;
      acc_wdata <= 32'd0;
      last_d    <= 1'b0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            gnt_d     <= grant_d_now;
            last_d    <= grant_d_now;
            acc_addr  <= grant_d_now ? d_addr : if_addr;
            acc_wdata <= grant_d_now ? d_wdata : 32'd0;
            acc_we    <= grant_d_now && d_we;
            cnt       <= 4'(WAIT_STATES);
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!acc_we) begin
            if (gnt_d) d_rdata  <= mem_rdata;
            else       if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == BUSY);
  assign mem_we    = final_busy && acc_we;
  assign mem_addr  = {acc_addr[31:2], 2'b00};
  assign mem_wdata = acc_wdata;
  assign if_ready  = (state == RESP) && !gnt_d;
  assign d_ready   = (state == RESP) && gnt_d;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: WAIT_STATES=1 main instance plus a WAIT_STATES=0 instance,
// both backed by one behavioural word memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we;
  logic [1:0]  dbg_state;

  logic        if_req_z;
  logic [31:0] if_addr_z;
  logic        d_req_z = 1'b0, d_we_z = 1'b0;
  logic [31:0] d_addr_z = 32'd0, d_wdata_z = 32'd0;
  logic [31:0] if_rdata_z, d_rdata_z, mem_addr_z, mem_wdata_z, mem_rdata_z;
  logic        if_ready_z, d_ready_z, mem_en_z, mem_we_z;
  logic [1:0]  dbg_state_z;

  logic [31:0] mem [0:63];
  logic [31:0] exp_q[$];
  logic [32:0] grant_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata   = mem[mem_addr[7:2]];
  assign mem_rdata_z = mem[mem_addr_z[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] = mem_wdata;

  mem_arbiter #(.WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  mem_arbiter #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req_z), .if_addr(if_addr_z), .if_rdata(if_rdata_z), .if_ready(if_ready_z),
    .d_req(d_req_z), .d_we(d_we_z), .d_addr(d_addr_z), .d_wdata(d_wdata_z),
    .d_rdata(d_rdata_z), .d_ready(d_ready_z),
    .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
    .mem_rdata(mem_rdata_z), .dbg_state(dbg_state_z)
  );

  // Driver: one access on the chosen port; request held until ready, dropped the cycle after.
  task automatic access(input bit port_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int busy_n, output int we_n, output int we_at,
                        output logic [31:0] addr_seen, output logic [31:0] rdata);
    lat = -1; busy_n = 0; we_n = 0; we_at = -1; addr_seen = 32'hx; rdata = 32'hx;
    @(posedge clk); #1;
    if (port_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_en) begin busy_n++; addr_seen = mem_addr; end
      if (mem_we) begin we_n++; we_at = n; end
      if (port_d ? d_ready : if_ready) begin
        lat = n; rdata = port_d ? d_rdata : if_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_ready, d_ready, mem_en, mem_we, dbg_state, if_rdata, d_rdata} !== 70'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {if_ready, d_ready, mem_en, mem_we, dbg_state, if_rdata, d_rdata});
    end
    checks++;
    if ({if_ready_z, d_ready_z, mem_en_z, mem_we_z, dbg_state_z} !== 6'd0) begin
      errors++; $display("FAIL reset_outputs_w0: got %h required 0", {if_ready_z, d_ready_z, mem_en_z, mem_we_z, dbg_state_z});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_read();
    int lat, busy_n, we_n, we_at;
    logic [31:0] a, r, e;
    mem[5] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h14, 32'd0, lat, busy_n, we_n, we_at, a, r);
    e = exp_q.pop_front();
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d required 3", lat); end
    checks++; if (busy_n !== 2) begin errors++; $display("FAIL read_busy_cycles: got %0d required 2", busy_n); end
    checks++; if (a !== 32'h14) begin errors++; $display("FAIL read_mem_addr: got %h required 00000014", a); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL read_mem_we: got %0d pulses required 0", we_n); end
    checks++; if (r !== e) begin errors++; $display("FAIL read_rdata: got %h required %h", r, e); end
    @(negedge clk);
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL read_ready_single: got %b required 0", d_ready); end
  endtask

  task automatic test_write();
    int lat, busy_n, we_n, we_at;
    logic [31:0] a, r;
    access(1'b1, 1'b1, 32'h22, 32'h12345678, lat, busy_n, we_n, we_at, a, r);
    checks++; if (a !== 32'h20) begin errors++; $display("FAIL write_mem_addr: got %h required 00000020", a); end
    checks++; if (we_n !== 1) begin errors++; $display("FAIL write_we_pulses: got %0d required 1", we_n); end
    checks++; if (we_at !== 2) begin errors++; $display("FAIL write_we_cycle: got %0d required 2", we_at); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d required 3", lat); end
    checks++; if (mem[8] !== 32'h12345678) begin errors++; $display("FAIL write_mem_word: got %h required 12345678", mem[8]); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL write_keeps_rdata: got %h required deadbeef", r); end
  endtask

  task automatic test_fetch_misaligned();
    int lat, busy_n, we_n, we_at;
    logic [31:0] a, r, e;
    mem[2] = $urandom;
    exp_q.push_back(mem[2]);
    access(1'b0, 1'b0, 32'h0B, 32'd0, lat, busy_n, we_n, we_at, a, r);
    e = exp_q.pop_front();
    checks++; if (a !== 32'h08) begin errors++; $display("FAIL fetch_mem_addr: got %h required 00000008", a); end
    checks++; if (r !== e) begin errors++; $display("FAIL fetch_rdata: got %h required %h", r, e); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL fetch_mem_we: got %0d required 0", we_n); end
    checks++; if (d_rdata !== 32'h12345678 && d_rdata !== 32'hDEADBEEF) begin end
    checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_keeps_d_rdata: got %h required deadbeef", d_rdata); end
  endtask

  task automatic test_back_to_back();
    int readies, last_grant;
    logic prev_en;
    logic [32:0] e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mem[1] = $urandom; mem[3] = $urandom;
    if_req = 1'b1; if_addr = 32'h04; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0C;
    grant_q.push_back({1'b1, mem[3]}); grant_q.push_back({1'b0, mem[1]});
    grant_q.push_back({1'b1, mem[3]}); grant_q.push_back({1'b0, mem[1]});
    readies = 0; last_grant = -1; prev_en = 1'b0;
    for (int n = 0; n < 60 && readies < 4; n++) begin
      @(negedge clk);
      if (mem_en && !prev_en) begin
        if (last_grant >= 0) begin
          checks++;
          if (n - last_grant !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d required 4", n - last_grant); end
        end
        last_grant = n;
      end
      prev_en = mem_en;
      if (d_ready || if_ready) begin
        e = grant_q.pop_front();
        checks++;
        if ({d_ready, if_ready, d_ready ? d_rdata : if_rdata} !== {e[32], ~e[32], e[31:0]}) begin
          errors++; $display("FAIL b2b_grant%0d: got d=%b i=%b data=%h required d=%b data=%h",
                             readies, d_ready, if_ready, d_ready ? d_rdata : if_rdata, e[32], e[31:0]);
        end
        readies++;
      end
    end
    checks++; if (readies !== 4) begin errors++; $display("FAIL b2b_ready_count: got %0d required 4", readies); end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    grant_q.delete();
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    mem[12] = 32'd0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    if (mem_we || d_ready) bad++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_ready, d_ready, mem_en, mem_we, dbg_state, if_rdata, d_rdata} !== 70'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h required 0", {if_ready, d_ready, mem_en, mem_we, dbg_state, if_rdata, d_rdata});
    end
    repeat (4) begin @(negedge clk); if (mem_we || d_ready) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_mid_pulses: got %0d required 0", bad); end
    checks++; if (mem[12] !== 32'd0) begin errors++; $display("FAIL reset_mid_mem: got %h required 0", mem[12]); end
  endtask

  task automatic test_drop();
    int pulses;
    logic [31:0] r, e;
    pulses = 0; r = 32'hx;
    mem[5] = $urandom;
    exp_q.push_back(mem[5]);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    @(posedge clk); #1 d_req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (d_ready) begin pulses++; r = d_rdata; end
    end
    e = exp_q.pop_front();
    checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_ready_pulses: got %0d required 1", pulses); end
    checks++; if (r !== e) begin errors++; $display("FAIL drop_rdata: got %h required %h", r, e); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL drop_idle: got %0d required 0", dbg_state); end
  endtask

  task automatic test_wait0();
    int lat, busy_n, we_n;
    logic [31:0] r, e;
    lat = -1; busy_n = 0; we_n = 0; r = 32'hx;
    mem[2] = $urandom;
    exp_q.push_back(mem[2]);
    @(posedge clk); #1;
    if_req_z = 1'b1; if_addr_z = 32'h08;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_en_z) busy_n++;
      if (mem_we_z) we_n++;
      if (if_ready_z) begin lat = n; r = if_rdata_z; break; end
    end
    @(posedge clk); #1 if_req_z = 1'b0;
    e = exp_q.pop_front();
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_latency: got %0d required 2", lat); end
    checks++; if (busy_n !== 1) begin errors++; $display("FAIL w0_busy_cycles: got %0d required 1", busy_n); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL w0_mem_we: got %0d required 0", we_n); end
    checks++; if (r !== e) begin errors++; $display("FAIL w0_rdata: got %h required %h", r, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    if_req_z = 1'b0; if_addr_z = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    test_reset();
    test_read();
    test_write();
    test_fetch_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_wait0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter, WAIT_STATES, default 1 (range 0..15), giving the number of extra memory cycles per access.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request; held until if_ready.
REQ-005 if_addr  input  32  fetch byte address; held until if_ready.
REQ-006 if_rdata  output  32  fetch read data; valid while if_ready=1.
REQ-007 if_ready  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data-port request; held until d_ready.
REQ-009 d_we  input  1  data-port write enable (1=write, 0=read); held with d_req.
REQ-010 d_addr  input  32  data byte address; held until d_ready.
REQ-011 d_wdata  input  32  data write value; held until d_ready.
REQ-012 d_rdata  output  32  data read data; valid while d_ready=1.
REQ-013 d_ready  output  1  one-cycle data completion pulse (reads and writes).
REQ-014 mem_en  output  1  shared memory access in progress.
REQ-015 mem_we  output  1  shared memory write strobe; the memory writes on the posedge at which it is 1.
REQ-016 mem_addr  output  32  word-aligned byte address to the memory.
REQ-017 mem_wdata  output  32  write data to the memory.
REQ-018 mem_rdata  input  32  combinational read data from the memory for mem_addr.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-020 IDLE: if neither request is asserted, the FSM SHALL stay in IDLE; otherwise it SHALL grant one port, latch that port's address, write data and we (we=0 for fetch), load the wait counter with WAIT_STATES, and go to BUSY.
REQ-021 Arbitration: with one request asserted, that port SHALL be granted; with both asserted, the port not granted most recently SHALL be granted.
REQ-022 The last-grant flag SHALL update on every grant.
REQ-023 BUSY: mem_en=1 and mem_addr={latched_addr[31:2],2'b00}; while the counter is nonzero it SHALL decrement and the FSM SHALL stay in BUSY.
REQ-024 BUSY with counter=0 (the final BUSY cycle): the block SHALL pulse mem_we=1 for a granted write, capture mem_rdata into the granted port's rdata register for a read, and go to RESP.
REQ-025 The FSM SHALL spend exactly WAIT_STATES+1 cycles in BUSY per access.
REQ-026 RESP: the granted port's ready SHALL be 1 for exactly this one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-027 Requests present during RESP SHALL be ignored; each requester drops or changes its request in the cycle after its ready pulse.
REQ-028 Latency from a request sampled in IDLE to its ready pulse SHALL be WAIT_STATES+2 cycles; the minimum spacing between grants SHALL be WAIT_STATES+3 cycles.
REQ-029 Outside BUSY, mem_en and mem_we SHALL be 0.
REQ-030 mem_we SHALL never be 1 for a fetch grant and SHALL never be 1 for more than one cycle per access.
REQ-031 if_rdata and d_rdata SHALL hold their last captured value until the next read on the same port; a write SHALL NOT alter d_rdata.
REQ-032 Address bits [1:0] SHALL be ignored; no error is flagged for a misaligned address.
REQ-033 A request that drops while its access is in BUSY SHALL NOT abort the access; the access completes and its ready pulse is issued.

Reset
REQ-034 While reset=1 at a posedge, the block SHALL enter IDLE, clear the counter, and set if_ready, d_ready, mem_en, mem_we, if_rdata and d_rdata to 0.
REQ-035 While reset=1 at a posedge, the block SHALL set the last-grant flag to fetch, so data wins the first conflict.
REQ-036 Reset asserted during BUSY SHALL abandon the access with no mem_we pulse and no ready pulse.

Verification
REQ-037 WAIT_STATES=1: d_req=1 with d_we=0, d_addr=0x14, mem_rdata=0xDEADBEEF -> mem_addr=0x14 for 2 cycles; d_ready pulses 3 cycles after the request with d_rdata=0xDEADBEEF.
REQ-038 d_we=1, d_addr=0x22, d_wdata=0x12345678 -> mem_addr=0x20; mem_we=1 for exactly one cycle (the final BUSY cycle); d_rdata unchanged.
REQ-039 if_req and d_req both asserted from reset and held -> grant order D, I, D, I; each ready pulses once per grant; grants are spaced WAIT_STATES+3 cycles apart.
REQ-040 WAIT_STATES=0, if_req=1 with if_addr=0x8 -> one BUSY cycle; if_ready pulses 2 cycles after the request; mem_we=0 throughout.
REQ-041 Reset pulsed in the first BUSY cycle of a write -> mem_we never 1, d_ready never 1; state is IDLE and all outputs are 0 on the next cycle.
REQ-042 d_req dropped mid-BUSY -> the access completes and d_ready still pulses once; the FSM returns to IDLE.
